store_buffer: RTL

Memory-stage store buffer between the load/store unit and the data-side AXI4 write channels. Committed stores from the LSU are queued in a small FIFO and drained one at a time as single-beat AXI4 writes, so that the pipeline does not stall on write-response latency. A load-address hazard check tells the LSU when a pending store overlaps a load. Bus errors and misaligned requests are reported as one-cycle pulses.

---
 rtl/store_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: queues committed LSU stores and drains them one at a time as single-beat AXI4 writes.
// Define STORE_BUF_HAZARD_EN to build the per-entry load-hazard address compare.
package defs_pkg;
    localparam int AxiIdW = 4;
endpackage

module store_buffer
    import defs_pkg::*;
#(
    parameter int                Depth = 4,
    parameter logic [AxiIdW-1:0] IdVal = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    input  logic [31:0]       ld_chk_addr,
    output logic              ld_hazard,
    output logic              sb_empty,
    output logic              err_misalign,
    output logic              err_bus,
    output logic [AxiIdW-1:0] axi_awid_m,
    output logic [31:0]       axi_awaddr_m,
    output logic [7:0]        axi_awlen_m,
    output logic [2:0]        axi_awsize_m,
    output logic [1:0]        axi_awburst_m,
    output logic              axi_awlock_m,
    output logic [3:0]        axi_awcache_m,
    output logic [2:0]        axi_awprot_m,
    output logic [3:0]        axi_awregion_m,
    output logic [3:0]        axi_awqos_m,
    output logic              axi_awvalid_m,
    input  logic              axi_awready_m,
    output logic [63:0]       axi_wdata_m,
    output logic [7:0]        axi_wstrb_m,
    output logic              axi_wlast_m,
    output logic              axi_wvalid_m,
    input  logic              axi_wready_m,
    input  logic [AxiIdW-1:0] axi_bid_m,
    input  logic [1:0]        axi_bresp_m,
    input  logic              axi_bvalid_m,
    output logic              axi_bready_m
);
    localparam int PtrW = $clog2(Depth);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

    state_t          state;
    logic [31:0]     mem_addr [Depth];
    logic [63:0]     mem_data [Depth];
    logic [7:0]      mem_strb [Depth];
    logic [1:0]      mem_size [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [PtrW:0]   count, count_nxt;
    logic            aligned, enq, pop;
    logic [7:0]      strb_base;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        aligned   = 1'b0;
        strb_base = 8'h00;
        case (st_size)
            2'd0: begin aligned = 1'b1;                strb_base = 8'h01; end
            2'd1: begin aligned = ~st_addr[0];         strb_base = 8'h03; end
            2'd2: begin aligned = (st_addr[1:0] == 2'b00); strb_base = 8'h0F; end
            default: ;
        endcase
    end

    // Ready comes from the registered count only: a pop never frees a slot in the same cycle.
    assign st_ready  = (count != (PtrW+1)'(Depth));
    assign enq       = st_valid & st_ready & aligned;
    assign pop       = (state == WAIT_B) & axi_bvalid_m;
    assign count_nxt = count + (PtrW+1)'(enq) - (PtrW+1)'(pop);
    assign sb_empty  = (count == '0) && (state == IDLE);

    // NOTE: entry storage has no reset; only slots inside the live count window are ever observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[wr_ptr] <= st_addr;
            mem_data[wr_ptr] <= {32'h0, st_data} << {st_addr[2:0], 3'b000};
            mem_strb[wr_ptr] <= strb_base << st_addr[2:0];
            mem_size[wr_ptr] <= st_size;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_misalign <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop) rd_ptr <= rd_ptr + PtrW'(1);
            count        <= count_nxt;
            err_misalign <= st_valid & st_ready & ~aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            axi_awvalid_m <= 1'b0;
            axi_wvalid_m  <= 1'b0;
            axi_bready_m  <= 1'b0;
            err_bus       <= 1'b0;
        end else begin
            err_bus <= 1'b0;
            case (state)
                IDLE: begin
                    if (count_nxt != '0) begin
                        state         <= SEND;
                        axi_awvalid_m <= 1'b1;
                        axi_wvalid_m  <= 1'b1;
                    end
                end
                SEND: begin
                    if (axi_awready_m) axi_awvalid_m <= 1'b0;
                    if (axi_wready_m)  axi_wvalid_m  <= 1'b0;
                    if ((!axi_awvalid_m || axi_awready_m) && (!axi_wvalid_m || axi_wready_m)) begin
                        state        <= WAIT_B;
                        axi_bready_m <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (axi_bvalid_m) begin
                        axi_bready_m <= 1'b0;
                        err_bus      <= (axi_bresp_m != 2'b00);
                        if (count_nxt != '0) begin
                            state         <= SEND;
                            axi_awvalid_m <= 1'b1;
                            axi_wvalid_m  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is the FIFO head, forced to zero whenever its channel is idle.
    assign axi_awid_m     = axi_awvalid_m ? IdVal : '0;
    assign axi_awaddr_m   = axi_awvalid_m ? mem_addr[rd_ptr] : '0;
    assign axi_awsize_m   = axi_awvalid_m ? {1'b0, mem_size[rd_ptr]} : '0;
    assign axi_awburst_m  = axi_awvalid_m ? 2'b01 : 2'b00;
    assign axi_awlen_m    = '0;
    assign axi_awlock_m   = 1'b0;
    assign axi_awcache_m  = '0;
    assign axi_awprot_m   = '0;
    assign axi_awregion_m = '0;
    assign axi_awqos_m    = '0;
    assign axi_wdata_m    = axi_wvalid_m ? mem_data[rd_ptr] : '0;
    assign axi_wstrb_m    = axi_wvalid_m ? mem_strb[rd_ptr] : '0;
    assign axi_wlast_m    = axi_wvalid_m;

`ifdef STORE_BUF_HAZARD_EN
    logic [Depth-1:0] hit;
    logic             unused_bits;

    always_comb begin
        hit = '0;
        for (int i = 0; i < Depth; i++) begin
            hit[i] = ({1'b0, PtrW'(i) - rd_ptr} < count) &&
                     (mem_addr[i][31:3] == ld_chk_addr[31:3]);
        end
    end

    assign ld_hazard   = |hit;
    assign unused_bits = ^{axi_bid_m, ld_chk_addr[2:0]};
`else
    logic unused_bits;

    // Conservative: any buffered store blocks every load until the buffer drains.
    assign ld_hazard   = !sb_empty;
    assign unused_bits = ^{axi_bid_m, ld_chk_addr};
`endif

endmodule
